// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, drives the synchronous imem,
// tracks the single in-flight read and buffers returned words in a 2-entry
// FIFO presented to decode over a valid/ready handshake. A redirect flushes
// everything buffered or in flight and restarts fetch at the target.
module instr_fetch_unit #(
    parameter int unsigned          ADDR_W   = 12,
    parameter int unsigned          DATA_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] address_imem,
    input  logic [DATA_W-1:0] q_imem,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc
);

    logic [ADDR_W-1:0] fetch_pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;

    // Two-entry queue kept as a shift structure: slot 0 is always the head.
    logic [1:0]        count;
    logic [DATA_W-1:0] data0, data1;
    logic [ADDR_W-1:0] pc0, pc1;

    logic       push, pop, issue, write_low;
    logic [1:0] count_next;

    assign address_imem = fetch_pc;
    assign instr_valid  = (count != 2'd0);
    assign instr_out    = data0;
    assign instr_pc     = pc0;

    // Handshake, occupancy look-ahead and issue decision.
    always_comb begin
        pop        = instr_valid & instr_ready;
        push       = inflight;
        count_next = count + 2'(push) - 2'(pop);
        issue      = !redirect_valid && (count_next <= 2'd1);
        // The returning word lands in slot 0 only if the head is empty after this pop.
        write_low  = (count == 2'd0) || ((count == 2'd1) && pop);
    end

    // Fetch PC and in-flight tracking; a redirect cancels issue for this cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else if (issue) begin
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + ADDR_W'(1);
        end else begin
            inflight <= 1'b0;
        end
    end

    // Queue update: flush on redirect, otherwise shift on pop and append on push.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= 2'd0;
            data0 <= '0;
            data1 <= '0;
            pc0   <= '0;
            pc1   <= '0;
        end else if (redirect_valid) begin
            count <= 2'd0;
        end else begin
            count <= count_next;
            if (pop) begin
                data0 <= data1;
                pc0   <= pc1;
            end
            if (push) begin
                if (write_low) begin
                    data0 <= q_imem;
                    pc0   <= inflight_pc;
                end else begin
                    data1 <= q_imem;
                    pc1   <= inflight_pc;
                end
            end
        end
    end

    // The issue rule never lets a word return into a full queue that is not draining.
    assert property (@(posedge clock) disable iff (!reset)
        !(push && !pop && (count == 2'd2)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit. The reference model
// tracks only the architectural stream: the PC the consumer should receive
// next, and how many cycles have passed since the last restart (the queue is
// empty for two cycles after a restart and never drains afterwards).
module tb_instr_fetch_unit;

    localparam logic [11:0] RST_PC = 12'h000;

    logic        clock;
    logic        reset;
    logic [11:0] address_imem;
    logic [31:0] q_imem;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [11:0] instr_pc;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [11:0] exp_pc;
    int          since;
    logic        hold_prev;
    logic [11:0] prev_pc;
    logic [31:0] prev_data;

    instr_fetch_unit #(
        .ADDR_W  (12),
        .DATA_W  (32),
        .RESET_PC(RST_PC)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address_imem  (address_imem),
        .q_imem        (q_imem),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] rom(input logic [11:0] a);
        return 32'hA000_0000 + {20'd0, a};
    endfunction

    // Synchronous ROM: data valid the cycle after the address is sampled.
    always @(posedge clock) q_imem <= rom(address_imem);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_restart(input logic [11:0] pc);
        exp_pc    = pc;
        since     = 0;
        hold_prev = 1'b0;
    endtask

    // One clock cycle: drive inputs at the falling edge, check, advance the model.
    task automatic step(input logic rdy, input logic rv, input logic [11:0] rpc);
        logic acc;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        chk("valid", {31'd0, instr_valid}, (since >= 2) ? 32'd1 : 32'd0);
        if (hold_prev) begin
            chk("hold_pc", {20'd0, instr_pc}, {20'd0, prev_pc});
            chk("hold_data", instr_out, prev_data);
        end
        acc = instr_valid && rdy && !rv;
        if (acc) begin
            chk("pc", {20'd0, instr_pc}, {20'd0, exp_pc});
            chk("data", instr_out, rom(exp_pc));
            exp_pc = exp_pc + 12'd1;
        end
        hold_prev = instr_valid && !rdy && !rv;
        prev_pc   = instr_pc;
        prev_data = instr_out;
        if (rv) begin
            exp_pc = rpc;
            since  = 0;
        end else if (since < 2) begin
            since++;
        end
        @(negedge clock);
    endtask

    task automatic chk_reset_state();
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_out", instr_out, 32'd0);
        chk("rst_pc", {20'd0, instr_pc}, 32'd0);
        chk("rst_addr", {20'd0, address_imem}, {20'd0, RST_PC});
    endtask

    initial begin
        reset          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        model_restart(RST_PC);
        prev_pc   = '0;
        prev_data = '0;

        repeat (2) @(negedge clock);
        chk_reset_state();

        // 1: release reset and stream
        reset = 1'b1;
        model_restart(RST_PC);
        repeat (7) step(1'b1, 1'b0, 12'h000);

        // 2: head is pc 5 now; stall three cycles then resume
        repeat (3) step(1'b0, 1'b0, 12'h000);
        repeat (6) step(1'b1, 1'b0, 12'h000);

        // 3: redirect while streaming
        step(1'b1, 1'b1, 12'h100);
        repeat (8) step(1'b1, 1'b0, 12'h000);

        // 4: fill the queue under backpressure, then redirect
        repeat (4) step(1'b0, 1'b0, 12'h000);
        step(1'b0, 1'b1, 12'h020);
        repeat (4) step(1'b0, 1'b0, 12'h000);
        repeat (5) step(1'b1, 1'b0, 12'h000);

        // back-to-back redirects: last one wins
        step(1'b1, 1'b1, 12'h300);
        step(1'b1, 1'b1, 12'h400);
        repeat (5) step(1'b1, 1'b0, 12'h000);

        // 5: wrap around the top of the address space
        step(1'b1, 1'b1, 12'hFFE);
        repeat (7) step(1'b1, 1'b0, 12'h000);

        // 6: reset mid-stream, asserted between edges
        #2;
        reset = 1'b0;
        #1;
        chk_reset_state();
        @(negedge clock);
        @(negedge clock);
        chk_reset_state();
        reset = 1'b1;
        model_restart(RST_PC);
        repeat (8) step(1'b1, 1'b0, 12'h000);

        // Randomized ready and redirect traffic
        for (int unsigned i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, ($urandom % 16) == 0, 12'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
